syscon_sink: RTL and testbench

- Receiving end of the system-controller pin interface: accepts the `clk_pin` / `rst_pin` pair driven by a remote syscon and turns them into local qualified signals.
- Synchronises both pins into the local clock domain.
- Detects edges of the pin clock and measures its period.
- Watches for a lost pin clock.
- Generates a locally stretched, synchronous-deassert reset for downstream logic.

---
 rtl/syscon_sink_if.sv | 25 ++
 rtl/syscon_sink.sv | 179 +++++++++++++++++
 tb/tb_syscon_sink.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/syscon_sink_if.sv
// Pin pair from a remote syscon plus the qualified local signals derived from it.
`timescale 1ns/1ps
interface syscon_sink_if #(
    parameter int PERIOD_W = 8
);
    logic                clk_pin;
    logic                rst_pin;
    logic                rst_out;
    logic                clk_rise;
    logic                clk_fall;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic                locked;
    logic                clk_lost;

    modport master (
        output clk_pin, rst_pin,
        input  rst_out, clk_rise, clk_fall, period, period_valid, locked, clk_lost
    );

    modport slave (
        input  clk_pin, rst_pin,
        output rst_out, clk_rise, clk_fall, period, period_valid, locked, clk_lost
    );
endinterface

// File: rtl/syscon_sink.sv
// syscon_sink: turns a remote clk_pin/rst_pin pair into local edge pulses, a period measure and a stretched reset.
// Optional macro SYSCON_SINK_GLITCH_FILTER_EN qualifies the synchronised rst_pin with a 3-sample filter.
`timescale 1ns/1ps
module syscon_sink #(
    parameter int SYNC_STAGES = 2,
    parameter int RST_HOLD    = 4,
    parameter int TIMEOUT     = 16,
    parameter int PERIOD_W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    syscon_sink_if.slave bus
);
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [IDLE_W-1:0]   IDLE_MAX  = IDLE_W'(TIMEOUT);
    localparam logic [PERIOD_W-1:0] PER_MAX   = '1;

    typedef enum logic [1:0] {HOLD = 2'd0, WAIT = 2'd1, RUN = 2'd2, LOST = 2'd3} state_t;

    state_t               state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] rst_sync;
    logic                 clk_pin_s;
    logic                 rst_pin_s;
    logic                 rst_pin_q;
    logic                 clk_pin_d;
    logic                 clk_rise;
    logic                 clk_fall;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [IDLE_W-1:0]    idle_cnt;
    logic [IDLE_W-1:0]    idle_next;
    logic                 idle_hit;
    logic [PERIOD_W-1:0]  per_cnt;
    logic [PERIOD_W-1:0]  period;
    logic                 period_valid;
    logic                 rst_out;
    logic                 locked;
    logic                 clk_lost;

    assign clk_pin_s = clk_sync[SYNC_STAGES-1];
    assign rst_pin_s = rst_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= '0;
            rst_sync  <= '0;
            clk_pin_d <= 1'b0;
            clk_rise  <= 1'b0;
            clk_fall  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.clk_pin};
            rst_sync  <= {rst_sync[SYNC_STAGES-2:0], bus.rst_pin};
            clk_pin_d <= clk_pin_s;
            clk_rise  <= clk_pin_s & ~clk_pin_d;
            clk_fall  <= ~clk_pin_s & clk_pin_d;
        end
    end

`ifdef SYSCON_SINK_GLITCH_FILTER_EN
    logic [1:0] rst_hist;
    logic       rst_filt;

    // The decision is taken combinationally so only two extra cycles are added each way.
    always_comb begin
        rst_pin_q = rst_filt;
        if (rst_pin_s && (&rst_hist))
            rst_pin_q = 1'b1;
        else if (!rst_pin_s && !(|rst_hist))
            rst_pin_q = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_hist <= 2'b00;
            rst_filt <= 1'b0;
        end else begin
            rst_hist <= {rst_hist[0], rst_pin_s};
            rst_filt <= rst_pin_q;
        end
    end
`else
    assign rst_pin_q = rst_pin_s;
`endif

    // An edge arriving in the very cycle the idle count would hit TIMEOUT clears it instead.
    always_comb begin
        if (clk_rise || clk_fall)
            idle_next = '0;
        else if (idle_cnt == IDLE_MAX)
            idle_next = IDLE_MAX;
        else
            idle_next = idle_cnt + IDLE_W'(1);
    end

    assign idle_hit = (idle_next == IDLE_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
            per_cnt  <= '0;
        end else begin
            idle_cnt <= idle_next;
            if (clk_rise)
                per_cnt <= PERIOD_W'(1);
            else if (per_cnt != PER_MAX)
                per_cnt <= per_cnt + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= HOLD;
            hold_cnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            rst_out      <= 1'b1;
            locked       <= 1'b0;
            clk_lost     <= 1'b0;
        end else begin
            // Outputs default to the non-RUN values; each branch sets them for the state it lands in.
            period_valid <= 1'b0;
            rst_out      <= 1'b1;
            locked       <= 1'b0;
            clk_lost     <= 1'b0;
            if (rst_pin_q) begin
                state    <= HOLD;
                hold_cnt <= '0;
            end else begin
                case (state)
                    HOLD: begin
                        if (hold_cnt == HOLD_LAST)
                            state <= WAIT;
                        else
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                    WAIT: begin
                        if (clk_rise) begin
                            state   <= RUN;
                            rst_out <= 1'b0;
                            locked  <= 1'b1;
                        end else if (idle_hit) begin
                            state    <= LOST;
                            clk_lost <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (idle_hit) begin
                            state    <= LOST;
                            clk_lost <= 1'b1;
                        end else begin
                            rst_out <= 1'b0;
                            locked  <= 1'b1;
                            if (clk_rise) begin
                                period       <= per_cnt;
                                period_valid <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (clk_rise || clk_fall)
                            state <= WAIT;
                        else
                            clk_lost <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.rst_out      = rst_out;
    assign bus.clk_rise     = clk_rise;
    assign bus.clk_fall     = clk_fall;
    assign bus.period       = period;
    assign bus.period_valid = period_valid;
    assign bus.locked       = locked;
    assign bus.clk_lost     = clk_lost;
endmodule

// File: tb/tb_syscon_sink.sv
// Directed bench for syscon_sink: lock-up, period measurement, clock loss, coincident events and resets.
`timescale 1ns/1ps
module tb_syscon_sink;
    localparam int PW = 4;
    localparam logic [31:0] ST_HOLD = 32'd0;
    localparam logic [31:0] ST_WAIT = 32'd1;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   nv;
    logic seen;

    syscon_sink_if #(.PERIOD_W(PW)) bus ();

    syscon_sink #(
        .SYNC_STAGES(2),
        .RST_HOLD   (4),
        .TIMEOUT    (16),
        .PERIOD_W   (PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle_tick();
        bus.clk_pin = ~bus.clk_pin;
        tick();
    endtask

    initial begin
        rst         = 1'b0;
        bus.rst_pin = 1'b1;
        bus.clk_pin = 1'b0;

        // 1: reset state, HOLD under rst_pin, stretch and first lock
        for (int i = 0; i < 4; i++) begin
            toggle_tick();
            check_eq("reset_rst_out", bus.rst_out, 1);
        end
        check_eq("reset_locked", bus.locked, 0);
        check_eq("reset_lost", bus.clk_lost, 0);
        check_eq("reset_period", bus.period, 0);
        check_eq("reset_pvalid", bus.period_valid, 0);
        check_eq("reset_rise", bus.clk_rise, 0);
        check_eq("reset_state", 32'(dut.state), ST_HOLD);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            toggle_tick();
            check_eq("pinrst_rst_out", bus.rst_out, 1);
            check_eq("pinrst_locked", bus.locked, 0);
        end
        bus.rst_pin = 1'b0;
        repeat (5) tick();
        check_eq("stretch_still_hold", 32'(dut.state), ST_HOLD);
        check_eq("stretch_rst_out", bus.rst_out, 1);
        tick();
        check_eq("stretch_to_wait", 32'(dut.state), ST_WAIT);
        check_eq("wait_rst_out", bus.rst_out, 1);
        check_eq("wait_locked", bus.locked, 0);
        bus.clk_pin = 1'b1;
        repeat (3) tick();
        check_eq("first_rise_pulse", bus.clk_rise, 1);
        check_eq("first_rise_not_locked", bus.locked, 0);
        tick();
        check_eq("lock_locked", bus.locked, 1);
        check_eq("lock_rst_out", bus.rst_out, 0);
        check_eq("lock_no_pvalid", bus.period_valid, 0);

        // 2: period measurement at several rates, including saturation
        repeat (6) toggle_tick();
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            toggle_tick();
            if (bus.period_valid) begin
                nv++;
                check_eq("fast_period", bus.period, 2);
            end
        end
        check_eq("fast_pvalid_count", nv, 4);
        for (int h = 0; h < 6; h++) begin
            bus.clk_pin = ~bus.clk_pin;
            repeat (5) tick();
        end
        repeat (4) tick();
        check_eq("period_10", bus.period, 10);
        check_eq("period_10_locked", bus.locked, 1);
        for (int h = 0; h < 6; h++) begin
            bus.clk_pin = ~bus.clk_pin;
            repeat (8) tick();
        end
        repeat (4) tick();
        check_eq("period_saturated", bus.period, 15);

        // 3: edge exactly at timeout boundary, then real loss and recovery
        if (bus.clk_pin == 1'b0) begin
            bus.clk_pin = 1'b1;
            repeat (6) tick();
        end
        bus.clk_pin = 1'b0;
        repeat (16) tick();
        bus.clk_pin = 1'b1;
        repeat (4) tick();
        check_eq("edge_wins_lost", bus.clk_lost, 0);
        check_eq("edge_wins_locked", bus.locked, 1);
        check_eq("edge_wins_pvalid", bus.period_valid, 1);
        repeat (15) tick();
        check_eq("pre_timeout_lost", bus.clk_lost, 0);
        check_eq("pre_timeout_locked", bus.locked, 1);
        tick();
        check_eq("timeout_lost", bus.clk_lost, 1);
        check_eq("timeout_rst_out", bus.rst_out, 1);
        check_eq("timeout_locked", bus.locked, 0);
        bus.clk_pin = 1'b0;
        repeat (2) tick();
        bus.clk_pin = 1'b1;
        repeat (2) tick();
        check_eq("recover_wait", 32'(dut.state), ST_WAIT);
        check_eq("recover_lost_clear", bus.clk_lost, 0);
        check_eq("recover_not_locked", bus.locked, 0);
        bus.clk_pin = 1'b0;
        tick();
        bus.clk_pin = 1'b1;
        tick();
        check_eq("recover_locked", bus.locked, 1);
        check_eq("recover_rst_out", bus.rst_out, 0);
        check_eq("recover_no_pvalid", bus.period_valid, 0);
        repeat (3) tick();
        check_eq("recover_pvalid", bus.period_valid, 1);
        check_eq("recover_period", bus.period, 3);

        // 4: rst_pin and clk_rise reach the FSM together
        bus.clk_pin = 1'b0;
        repeat (2) tick();
        bus.clk_pin = 1'b1;
        tick();
        bus.rst_pin = 1'b1;
        repeat (2) tick();
        check_eq("coinc_pre_locked", bus.locked, 1);
        check_eq("coinc_pre_rise", bus.clk_rise, 1);
        tick();
        check_eq("coinc_rst_out", bus.rst_out, 1);
        check_eq("coinc_locked", bus.locked, 0);
        check_eq("coinc_no_pvalid", bus.period_valid, 0);
        check_eq("coinc_period_kept", bus.period, 3);
        check_eq("coinc_state", 32'(dut.state), ST_HOLD);

        // 5: local reset pulse mid-RUN
        bus.rst_pin = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            toggle_tick();
            seen = bus.locked;
        end
        check_eq("relock_after_pin_rst", seen, 1);
        repeat (4) toggle_tick();
        #2 rst = 1'b0;
        #0.5;
        check_eq("async_rst_out", bus.rst_out, 1);
        check_eq("async_locked", bus.locked, 0);
        check_eq("async_period", bus.period, 0);
        check_eq("async_pvalid", bus.period_valid, 0);
        check_eq("async_lost", bus.clk_lost, 0);
        #0.5 rst = 1'b1;
        repeat (3) toggle_tick();
        check_eq("rerun_hold", 32'(dut.state), ST_HOLD);
        check_eq("rerun_rst_out", bus.rst_out, 1);
        toggle_tick();
        check_eq("rerun_wait", 32'(dut.state), ST_WAIT);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            toggle_tick();
            if (bus.locked) begin
                seen = 1'b1;
                check_eq("rerun_lock_no_pvalid", bus.period_valid, 0);
            end
        end
        check_eq("rerun_locked", seen, 1);

        // 6: single-cycle rst_pin glitch in RUN
        repeat (4) toggle_tick();
        bus.rst_pin = 1'b1;
        toggle_tick();
        bus.rst_pin = 1'b0;
        toggle_tick();
        toggle_tick();
`ifdef SYSCON_SINK_GLITCH_FILTER_EN
        check_eq("glitch_locked", bus.locked, 1);
        check_eq("glitch_rst_out", bus.rst_out, 0);
`else
        check_eq("glitch_locked", bus.locked, 0);
        check_eq("glitch_rst_out", bus.rst_out, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
